// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_ctrl
//  Purpose  : Run-time clock divider with glitch-free start/stop and a
//             load/ack divisor handshake applied at falling-toggle boundaries.
//  Revision : 1.0 - initial release
// ============================================================================
module clk_div_ctrl #(
  parameter int          c_width            = 16,
  parameter int unsigned c_div_half_default = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [c_width-1:0] i_div_half,
  input  logic               i_div_load,
  output logic               o_div_ack,
  output logic               o_div_err,
  output logic [c_width-1:0] o_div_cur,
  output logic               o_clk,
  output logic               o_rise,
  output logic               o_fall,
  output logic               o_running
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  localparam logic [c_width-1:0] c_cur_rst = c_width'(c_div_half_default);
  localparam logic [c_width-1:0] c_one     = c_width'(1);

  state_t             state_q, state_d;
  logic [c_width-1:0] cnt_q, cnt_d;
  logic [c_width-1:0] cur_q, cur_d;
  logic [c_width-1:0] pend_q, pend_d;
  logic               pend_vld_q, pend_vld_d;
  logic               clk_q, clk_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               running_q, running_d;

  logic w_terminal;
  logic w_advance;
  logic w_apply;

  // cur_q is never zero, so cur_q-1 cannot wrap and the full-width compare is exact
  assign w_terminal = (cnt_q == (cur_q - c_one));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clk_d      = clk_q;
    cur_d      = cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    w_advance  = 1'b0;
    w_apply    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        clk_d   = 1'b0;
        w_apply = pend_vld_q;
        if (i_start && !i_stop) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_stop && !clk_q) begin
          // Low phase: stopping now cannot shorten a high pulse
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          w_advance = 1'b1;
          if (i_stop) begin
            state_d = w_terminal ? ST_IDLE : ST_STOPPING;
          end
        end
      end
      ST_STOPPING: begin
        w_advance = 1'b1;
        if (i_start && !i_stop) begin
          state_d = ST_RUN;
        end else if (w_terminal) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        clk_d   = 1'b0;
      end
    endcase

    if (w_advance) begin
      if (w_terminal) begin
        cnt_d   = '0;
        clk_d   = ~clk_q;
        rise_d  = ~clk_q;
        fall_d  = clk_q;
        w_apply = clk_q && pend_vld_q;
      end else begin
        cnt_d = cnt_q + c_one;
      end
    end

    if (w_apply) begin
      cur_d      = pend_q;
      pend_vld_d = 1'b0;
      ack_d      = 1'b1;
    end

    // A load coinciding with an apply re-arms pending after the older value is used
    if (i_div_load) begin
      if (i_div_half != '0) begin
        pend_d     = i_div_half;
        pend_vld_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    running_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cur_q      <= c_cur_rst;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_q      <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_q      <= clk_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      running_q  <= running_d;
    end
  end

  assign o_div_ack = ack_q;
  assign o_div_err = err_q;
  assign o_div_cur = cur_q;
  assign o_clk     = clk_q;
  assign o_rise    = rise_q;
  assign o_fall    = fall_q;
  assign o_running = running_q;

endmodule
`default_nettype wire

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Run-time controller for the lamp's clock divider.
- Generates a divided clock level plus edge-aligned one-cycle strobes from i_clk.
- Starts and stops the divided clock without runt pulses, and accepts divisor changes through a load/ack handshake.
- Changes are applied only at safe period boundaries.
- Downstream LED-driver logic consumes o_rise/o_fall as clock enables or o_clk as a slow shift clock.

Parameters:
- c_width, 16: width of the half-period counter and divisor input.
- c_div_half_default, 2: half-period (in i_clk cycles) loaded at reset. Must be >= 1 and < 2^c_width.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  start request, sampled each cycle.
- i_stop  in  1  stop request, sampled each cycle.
- i_div_half  in  c_width  requested half-period in i_clk cycles.
- i_div_load  in  1  one-cycle strobe; captures i_div_half.
- o_div_ack  out  1  one-cycle pulse; pending divisor has been applied.
- o_div_err  out  1  one-cycle pulse; load rejected (i_div_half == 0).
- o_div_cur  out  c_width  half-period currently in effect.
- o_clk  out  1  divided clock, registered.
- o_rise  out  1  high in the same cycle o_clk goes 0->1.
- o_fall  out  1  high in the same cycle o_clk goes 1->0.
- o_running  out  1  high when state != IDLE.

Behaviour:
- Reset (async, while i_rst_n low):
  - state=IDLE; o_clk, o_rise, o_fall, o_div_ack, o_div_err, o_running = 0.
  - Counter = 0; o_div_cur = c_div_half_default; pending flag clear.
  - Reset asserted mid-operation forces these values immediately, with no completion of the current period.
- States: IDLE, RUN, STOPPING. All outputs are registered.
- IDLE:
  - o_clk held 0; counter held 0.
  - i_start (with i_stop low) -> RUN next cycle.
- RUN:
  - Counter increments each cycle.
  - When counter == o_div_cur-1: counter <= 0 and o_clk toggles; o_rise/o_fall assert for that single cycle.
  - First o_rise occurs o_div_cur cycles after the cycle RUN is entered. Output period = 2*o_div_cur cycles, 50% duty.
  - i_start is ignored in RUN.
- Stop:
  - i_stop in RUN with o_clk==0 -> IDLE next cycle; counter cleared; no further edges.
  - i_stop in RUN with o_clk==1 -> STOPPING. Counting continues to the next falling toggle (o_fall asserts), then IDLE.
  - Full high phase is always preserved.
  - i_start and i_stop in the same cycle: stop wins.
- STOPPING:
  - i_start (without i_stop) cancels the stop -> RUN; counter and o_clk are undisturbed.
- Divisor load:
  - i_div_load with i_div_half != 0 captures the value into pending and sets the pending flag.
  - i_div_load with i_div_half == 0 pulses o_div_err next cycle; pending is unchanged.
  - Apply point is the next falling toggle in RUN/STOPPING, or the next cycle in IDLE.
  - At apply: o_div_cur <= pending, flag cleared, o_div_ack pulses in the same cycle o_div_cur updates. The new value governs the low phase that follows.
  - Load while already pending: last value wins; one ack only.
  - Load in the same cycle as an apply: the older pending is applied and acked; the new value becomes pending for the next boundary.
- Counter width: compare uses the full c_width bits. o_div_cur = 2^c_width-1 is legal; the counter never wraps past o_div_cur-1.

Test Plan:
- Reset, then i_start with default 2 -> o_running=1 next cycle; o_clk period 4 cycles; o_rise 2 cycles after RUN entry; o_rise/o_fall each one cycle wide, coincident with o_clk edges.
- Running at half=2, load i_div_half=5 while o_clk high -> o_div_ack and o_div_cur=5 on the falling toggle; following low phase 5 cycles; subsequent period 10 cycles.
- Two loads (3 then 7) before a boundary -> single ack, o_div_cur=7; load of 0 -> o_div_err pulse, o_div_cur unchanged.
- i_stop during high phase at half=4 -> o_clk stays high for the full 4 cycles, o_fall, then IDLE with o_running=0. i_stop during low phase -> IDLE next cycle with no o_rise.
- In STOPPING, assert i_start -> returns to RUN with period unbroken. i_start+i_stop in the same cycle from IDLE -> remains IDLE.
- Assert i_rst_n low mid-high-phase with a load pending -> o_clk=0, o_running=0, o_div_cur=c_div_half_default immediately; no ack after release.
